// File: rtl/reaction_timer_pkg.sv
// Shared types and helpers for the multi-channel reaction timer.
// Pure declarations: no logic, no latency.
package reaction_timer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DELAY = 2'd1,
      STIM  = 2'd2,
      DONE  = 2'd3
   } rt_state_t;

   localparam int                LFSR_W    = 8;
   // Shift-left Fibonacci taps for x^8+x^6+x^5+x^4+1, feedback enters bit 0
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 8'hFF;

   function automatic logic [3:0] clamp_delay(input logic [3:0] raw, input int min_s, input int max_s);
      logic [3:0] d;
      if (int'(raw) < min_s)
         d = 4'(min_s);
      else if (int'(raw) > max_s)
         d = 4'(max_s);
      else
         d = raw;
      return d;
   endfunction

endpackage

// File: rtl/ms_prescaler.sv
// Free-running 1 ms tick generator; tick is combinational on the terminal count.
// sync_clr restarts the period so the first tick lands CLK_HZ/1000 cycles later.
module ms_prescaler #(
   parameter int CLK_HZ = 100_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic sync_clr,
   output logic ms_tick
);

   localparam int P  = CLK_HZ / 1000;
   localparam int CW = (P > 1) ? $clog2(P) : 1;
   localparam logic [CW-1:0] TERM = CW'(P - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (sync_clr || cnt == TERM)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign ms_tick = (cnt == TERM);

endmodule

// File: rtl/reaction_timer_mc.sv
// Multi-channel reaction timer: random delay, stimulus, per-channel ms capture, winner and best time.
// All outputs registered; results visible one cycle after the capturing stop pulse.
module reaction_timer_mc
   import reaction_timer_pkg::*;
#(
   parameter int CLK_HZ    = 100_000_000,
   parameter int N_CH      = 2,
   parameter int TIME_W    = 14,
   parameter int MAX_MS    = 9999,
   parameter int MIN_DLY_S = 2,
   parameter int MAX_DLY_S = 15
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     start,
   input  logic                                     clear,
   input  logic [N_CH-1:0]                          stop,
   output logic                                     stim_led,
   output logic                                     busy,
   output logic                                     done,
   output logic [N_CH-1:0]                          false_start,
   output logic [N_CH*TIME_W-1:0]                   rt_ms,
   output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] winner,
   output logic                                     winner_valid,
   output logic [TIME_W-1:0]                        best_ms
);

   localparam int                WIN_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic [TIME_W-1:0] MAX_T  = TIME_W'(MAX_MS);
   localparam logic [TIME_W-1:0] SAT_M1 = TIME_W'(MAX_MS - 1);
   localparam logic [TIME_W-1:0] MS_END = TIME_W'(999);

   rt_state_t         state, state_nxt;
   logic [LFSR_W-1:0] lfsr;
   logic [3:0]        dly_s, sec_cnt;
   logic [TIME_W-1:0] ms_cnt;
   logic [N_CH-1:0]   lock, lock_nxt, fs_nxt;
   logic [TIME_W-1:0] rt_q   [N_CH];
   logic [TIME_W-1:0] rt_nxt [N_CH];
   logic              ms_tick, go_delay, go_stim, sat_hit;
   logic              stim_nxt, busy_nxt, done_nxt, enter_done;
   logic [WIN_W-1:0]  win_idx;
   logic              win_vld;
   logic [TIME_W-1:0] win_time;

   assign go_delay = (state == IDLE) && start && !clear;
   // ms_cnt doubles as the 0..999 sub-second count while in DELAY
   assign go_stim  = (state == DELAY) && ms_tick && (ms_cnt == MS_END) &&
                     (({1'b0, sec_cnt} + 5'd1) == {1'b0, dly_s});
   assign sat_hit  = (state == STIM) && ms_tick && (ms_cnt == SAT_M1);

   ms_prescaler #(.CLK_HZ(CLK_HZ)) u_prescaler (
      .clk      (clk),
      .rst      (rst),
      .sync_clr (go_delay || go_stim),
      .ms_tick  (ms_tick)
   );

   always_comb begin
      lock_nxt = lock;
      fs_nxt   = false_start;
      rt_nxt   = rt_q;
      for (int c = 0; c < N_CH; c++) begin
         if (clear || go_delay) begin
            lock_nxt[c] = 1'b0;
            fs_nxt[c]   = 1'b0;
            rt_nxt[c]   = '0;
         end else if (state == DELAY && stop[c] && !lock[c]) begin
            lock_nxt[c] = 1'b1;
            fs_nxt[c]   = 1'b1;
            rt_nxt[c]   = MAX_T;
         end else if (state == STIM && !lock[c]) begin
            if (stop[c]) begin
               lock_nxt[c] = 1'b1;
               rt_nxt[c]   = ms_cnt;
            end else if (sat_hit) begin
               lock_nxt[c] = 1'b1;
               rt_nxt[c]   = MAX_T;
            end
         end
      end
   end

   // Strict less-than keeps the lowest index on ties
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_time = MAX_T;
      for (int c = 0; c < N_CH; c++) begin
         if (lock_nxt[c] && !fs_nxt[c] && rt_nxt[c] < MAX_T && (!win_vld || rt_nxt[c] < win_time)) begin
            win_vld  = 1'b1;
            win_idx  = WIN_W'(c);
            win_time = rt_nxt[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear)
         state_nxt = IDLE;
      else begin
         case (state)
            IDLE:    if (start) state_nxt = DELAY;
            DELAY:   if (&lock_nxt) state_nxt = DONE;
                     else if (go_stim) state_nxt = STIM;
            STIM:    if (&lock_nxt || sat_hit) state_nxt = DONE;
            default: state_nxt = state;
         endcase
      end
   end

   always_comb begin
      stim_nxt   = (state_nxt == STIM);
      busy_nxt   = (state_nxt == DELAY) || (state_nxt == STIM);
      done_nxt   = (state_nxt == DONE);
      enter_done = (state_nxt == DONE) && (state != DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lfsr         <= LFSR_SEED;
         dly_s        <= '0;
         sec_cnt      <= '0;
         ms_cnt       <= '0;
         lock         <= '0;
         false_start  <= '0;
         rt_q         <= '{default: '0};
         stim_led     <= 1'b0;
         busy         <= 1'b0;
         done         <= 1'b0;
         winner       <= '0;
         winner_valid <= 1'b0;
         best_ms      <= MAX_T;
      end else begin
         if (state == IDLE)
            lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & LFSR_TAPS)};
         if (go_delay)
            dly_s <= clamp_delay(lfsr[3:0], MIN_DLY_S, MAX_DLY_S);

         if (go_delay || go_stim) begin
            sec_cnt <= '0;
            ms_cnt  <= '0;
         end else if (state == DELAY && ms_tick) begin
            if (ms_cnt == MS_END) begin
               ms_cnt  <= '0;
               sec_cnt <= sec_cnt + 4'd1;
            end else
               ms_cnt <= ms_cnt + TIME_W'(1);
         end else if (state == STIM && ms_tick && ms_cnt != MAX_T)
            ms_cnt <= ms_cnt + TIME_W'(1);

         lock        <= lock_nxt;
         false_start <= fs_nxt;
         rt_q        <= rt_nxt;
         stim_led    <= stim_nxt;
         busy        <= busy_nxt;
         done        <= done_nxt;

         if (clear || go_delay) begin
            winner       <= '0;
            winner_valid <= 1'b0;
         end else if (enter_done) begin
            winner       <= win_idx;
            winner_valid <= win_vld;
            if (win_vld && win_time < best_ms)
               best_ms <= win_time;
         end
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : g_ch
      assign rt_ms[c*TIME_W +: TIME_W] = rt_q[c];
   end

endmodule

// File: tb/tb_reaction_timer_mc.sv
// Directed bench for reaction_timer_mc with a 2 kHz clock (2 cycles per ms).
module tb_reaction_timer_mc;

   localparam int CLK_HZ    = 2000;
   localparam int N_CH      = 2;
   localparam int TIME_W    = 14;
   localparam int MAX_MS    = 9999;
   localparam int MIN_DLY_S = 2;
   localparam int MAX_DLY_S = 3;
   localparam int P         = CLK_HZ / 1000;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     start;
   logic                     clear;
   logic [N_CH-1:0]          stop;
   logic                     stim_led;
   logic                     busy;
   logic                     done;
   logic [N_CH-1:0]          false_start;
   logic [N_CH*TIME_W-1:0]   rt_ms;
   logic [0:0]               winner;
   logic                     winner_valid;
   logic [TIME_W-1:0]        best_ms;

   int   n_cmp = 0;
   int   n_bad = 0;
   bit   ok;
   logic [7:0] lf;
   int   m;

   always #5 clk = ~clk;

   reaction_timer_mc #(
      .CLK_HZ    (CLK_HZ),
      .N_CH      (N_CH),
      .TIME_W    (TIME_W),
      .MAX_MS    (MAX_MS),
      .MIN_DLY_S (MIN_DLY_S),
      .MAX_DLY_S (MAX_DLY_S)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .clear        (clear),
      .stop         (stop),
      .stim_led     (stim_led),
      .busy         (busy),
      .done         (done),
      .false_start  (false_start),
      .rt_ms        (rt_ms),
      .winner       (winner),
      .winner_valid (winner_valid),
      .best_ms      (best_ms)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic pulse_stop(input logic [N_CH-1:0] s);
      stop = s;
      step();
      stop = '0;
   endtask

   task automatic wait_stim(input int bound, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < bound; i++) begin
         step();
         if (stim_led === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      clear = 1'b0;
      stop  = '0;
      repeat (3) step();

      check("rst_stim",  32'(stim_led), 0);
      check("rst_busy",  32'(busy), 0);
      check("rst_done",  32'(done), 0);
      check("rst_fs",    32'(false_start), 0);
      check("rst_rt",    32'(rt_ms), 0);
      check("rst_win",   32'(winner), 0);
      check("rst_wv",    32'(winner_valid), 0);
      check("rst_best",  32'(best_ms), 9999);

      // LFSR seed 8'hFF -> nibble F -> clamped to 3 s
      rst = 1'b0;
      pulse_start();
      check("norm_busy", 32'(busy), 1);
      repeat (3*CLK_HZ - 1) step();
      check("norm_dly_before", 32'(stim_led), 0);
      step();
      check("norm_dly_edge", 32'(stim_led), 1);
      repeat (25) step();
      pulse_stop(2'b01);
      check("norm_rt0_first", 32'(rt_ms[13:0]), 12);
      check("norm_not_done",  32'(done), 0);
      repeat (25) step();
      pulse_stop(2'b11);
      check("norm_rt0",  32'(rt_ms[13:0]), 12);
      check("norm_rt1",  32'(rt_ms[27:14]), 25);
      check("norm_done", 32'(done), 1);
      check("norm_stim", 32'(stim_led), 0);
      check("norm_busy_lo", 32'(busy), 0);
      check("norm_win",  32'(winner), 0);
      check("norm_wv",   32'(winner_valid), 1);
      check("norm_best", 32'(best_ms), 12);

      pulse_start();
      check("done_ignores_start", 32'(done), 1);

      pulse_clear();
      check("clr_done", 32'(done), 0);
      check("clr_busy", 32'(busy), 0);
      check("clr_rt",   32'(rt_ms), 0);
      check("clr_wv",   32'(winner_valid), 0);
      check("clr_best", 32'(best_ms), 12);

      clear = 1'b1;
      start = 1'b1;
      step();
      clear = 1'b0;
      start = 1'b0;
      check("clr_start_idle0", 32'(busy), 0);
      step();
      check("clr_start_idle1", 32'(busy), 0);

      pulse_start();
      check("fs_busy", 32'(busy), 1);
      repeat (10) step();
      pulse_stop(2'b10);
      check("fs_flag_dly", 32'(false_start), 2);
      check("fs_rt1_dly",  32'(rt_ms[27:14]), 9999);
      check("fs_not_done", 32'(done), 0);
      wait_stim(7000, ok);
      check("fs_stim_seen", 32'(ok), 1);
      repeat (9) step();
      pulse_stop(2'b01);
      check("fs_rt0",  32'(rt_ms[13:0]), 4);
      check("fs_rt1",  32'(rt_ms[27:14]), 9999);
      check("fs_flag", 32'(false_start), 2);
      check("fs_win",  32'(winner), 0);
      check("fs_wv",   32'(winner_valid), 1);
      check("fs_done", 32'(done), 1);
      check("fs_best", 32'(best_ms), 4);

      pulse_clear();
      pulse_start();
      wait_stim(7000, ok);
      check("tie_stim_seen", 32'(ok), 1);
      repeat (15) step();
      pulse_stop(2'b11);
      check("tie_rt0",  32'(rt_ms[13:0]), 7);
      check("tie_rt1",  32'(rt_ms[27:14]), 7);
      check("tie_win",  32'(winner), 0);
      check("tie_wv",   32'(winner_valid), 1);
      check("tie_done", 32'(done), 1);
      check("tie_best", 32'(best_ms), 4);

      pulse_clear();
      pulse_start();
      repeat (5) step();
      pulse_stop(2'b11);
      check("afs_done", 32'(done), 1);
      check("afs_stim", 32'(stim_led), 0);
      check("afs_fs",   32'(false_start), 3);
      check("afs_rt",   32'(rt_ms), {14'd9999, 14'd9999});
      check("afs_wv",   32'(winner_valid), 0);
      check("afs_best", 32'(best_ms), 4);

      pulse_clear();
      pulse_start();
      wait_stim(7000, ok);
      check("ar_stim_seen", 32'(ok), 1);
      repeat (7) step();
      #2 rst = 1'b1;
      #1;
      check("ar_stim", 32'(stim_led), 0);
      check("ar_busy", 32'(busy), 0);
      check("ar_done", 32'(done), 0);
      check("ar_rt",   32'(rt_ms), 0);
      check("ar_fs",   32'(false_start), 0);
      check("ar_wv",   32'(winner_valid), 0);
      check("ar_best", 32'(best_ms), 9999);
      step();

      // Find how many IDLE shifts from seed give low nibble 1 (clamped up to 2 s)
      lf = 8'hFF;
      m  = 0;
      while (lf[3:0] != 4'h1 && m < 300) begin
         lf = {lf[6:0], lf[7] ^ lf[5] ^ lf[4] ^ lf[3]};
         m++;
      end
      rst = 1'b0;
      repeat (m) step();
      pulse_start();
      repeat (2*CLK_HZ - 1) step();
      check("clamp_dly_before", 32'(stim_led), 0);
      step();
      check("clamp_dly_edge", 32'(stim_led), 1);
      repeat (MAX_MS*P - 1) step();
      check("sat_not_done", 32'(done), 0);
      step();
      check("sat_done", 32'(done), 1);
      check("sat_stim", 32'(stim_led), 0);
      check("sat_rt",   32'(rt_ms), {14'd9999, 14'd9999});
      check("sat_fs",   32'(false_start), 0);
      check("sat_wv",   32'(winner_valid), 0);
      check("sat_win",  32'(winner), 0);
      check("sat_best", 32'(best_ms), 9999);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/reaction_timer_mc.md
# reaction_timer_mc

Multi-channel, parametrised reaction-timer core: a pseudo-random delay after `start`, then a stimulus, then a millisecond time per player channel. Adds false-start detection, a winner, and a best-time-since-reset register. Sits between the per-button debouncers and the BCD/seven-segment display path. Inputs are single-cycle, already-debounced pulses.

## Interface

Parameters
- `CLK_HZ`, 100_000_000: clock frequency; ms tick every `CLK_HZ/1000` cycles.
- `N_CH`, 2: player channels, 1..8.
- `TIME_W`, 14: result width.
- `MAX_MS`, 9999: saturation value; must be below 2^`TIME_W`.
- `MIN_DLY_S`, 2: minimum random delay in seconds.
- `MAX_DLY_S`, 15: maximum random delay in seconds; `MIN_DLY_S` ≤ `MAX_DLY_S` ≤ 15.

Ports
- `clk`, in, 1: single clock; all logic on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: arm pulse.
- `clear`, in, 1: abort/clear pulse.
- `stop`, in, `N_CH`: per-channel reaction pulse.
- `stim_led`, out, 1: stimulus.
- `busy`, out, 1: high in DELAY or STIM.
- `done`, out, 1: high in DONE.
- `false_start`, out, `N_CH`: channel pressed before the stimulus.
- `rt_ms`, out, `N_CH*TIME_W`: channel c result at bits [c*`TIME_W` +: `TIME_W`].
- `winner`, out, `$clog2(N_CH)` (min 1): fastest valid channel.
- `winner_valid`, out, 1: at least one non-false-start channel stopped before saturation.
- `best_ms`, out, `TIME_W`: best winning time since reset.

## Operation

- Reset values:
  - state IDLE.
  - All 1-bit outputs 0.
  - `rt_ms` all 0; `winner` 0.
  - `best_ms` = `MAX_MS`.
  - LFSR = 8'hFF.
- LFSR: 8-bit Fibonacci, x^8+x^6+x^5+x^4+1. Shifts every cycle in IDLE only; holds otherwise.
- Delay selection:
  - On `start` in IDLE: d = LFSR[3:0], clamped to [`MIN_DLY_S`, `MAX_DLY_S`].
  - Latch d, clear the per-channel results/flags, and enter DELAY.
- States:
  - IDLE: `start` → DELAY. `stop` ignored.
  - DELAY:
    - Prescaler and seconds counter start from 0.
    - `stop[c]` sets `false_start[c]`, sets `rt_ms[c]`=`MAX_MS`, and locks channel c.
    - If all channels are locked → DONE.
    - When the seconds count equals d → STIM.
  - STIM:
    - `stim_led`=1; ms counter starts at 0 and saturates at `MAX_MS`.
    - `stop[c]` on an unlocked channel latches the current ms count into `rt_ms[c]` and locks c.
    - When all channels are locked, or the ms count reaches `MAX_MS`, go to DONE. On saturation, unlocked channels get `MAX_MS`.
  - DONE:
    - `stim_led`=0; results hold.
    - `clear` → IDLE. `start` is ignored.
- Winner: lowest `rt_ms` among non-false-start channels with value < `MAX_MS`. Ties go to the lowest index. Computed on DONE entry.
- `best_ms` update: on DONE entry, if `winner_valid` and the winner's time < `best_ms`, load it. `clear` never touches `best_ms`.
- `clear`:
  - In any state → IDLE next cycle.
  - Zeroes `rt_ms`, `false_start`, `winner`, `winner_valid`.
  - Has priority over `start` and `stop` in the same cycle.
- `start` is ignored outside IDLE.
- Multiple `stop` bits in one cycle are each handled independently.
- Repeated `stop` on a locked channel is ignored.
- An asynchronous `rst` mid-run returns everything to the reset values immediately.

## Timing

- All outputs are registered.
- `stim_led` rises 1 cycle after the seconds count equals d; call that cycle S.
- Ms tick period P = `CLK_HZ/1000` cycles, counted from S.
- `stop` at cycle S+k captures floor(k/P), visible on `rt_ms` at S+k+1.
- `done`, `winner`, `winner_valid` and `best_ms` are valid 1 cycle after the final lock or saturation.
- DELAY length: exactly d·`CLK_HZ` cycles from the cycle after `start`.

## Structure

- Package `reaction_timer_pkg` holds:
  - state enum `rt_state_t` {IDLE, DELAY, STIM, DONE}, 2 bits.
  - LFSR width and taps constants.
  - function `clamp_delay`.
- Sub-module `ms_prescaler`:
  - Parameter `CLK_HZ`; ports `clk`, `rst`, `sync_clr`, `ms_tick`.
  - Instantiated once; a second internal count of 1000 ticks forms the seconds counter.
- The main module holds the FSM, LFSR, per-channel generate loop and the winner reduction.

## Test plan

Bench parameters: `CLK_HZ`=10_000 (P=10), `N_CH`=2.

- Reset and simultaneous-event checks:
  - Assert `rst` mid-STIM → all outputs return to reset values asynchronously; `best_ms`=9999.
  - Pulse `clear` and `start` in the same IDLE cycle → stays IDLE, no DELAY entry.
- Normal run: `start` with LFSR[3:0]=4'hF, `stop[0]` at S+123, `stop[1]` at S+250 → `rt_ms`={25,12}, `winner`=0, `winner_valid`=1, `best_ms`=12.
- False start: `stop[1]` during DELAY, `stop[0]` at S+40 → `false_start`=2'b10, `rt_ms[1]`=9999, `winner`=0, `rt_ms[0]`=4.
- Tie and all-false-start:
  - Both stops in the same cycle at S+70 → both `rt_ms`=7, `winner`=0.
  - Both channels false-start → DONE without `stim_led` ever rising, `winner_valid`=0, `best_ms` unchanged.
- Saturation and clamping:
  - No stops → DONE at S+99990, both `rt_ms`=9999, `winner_valid`=0.
  - LFSR[3:0]=4'h1 → d clamped to 2, so DELAY lasts 20_000 cycles.
